// File: rtl/pixel_pkg.sv
// Shared types for the pixel packer: FSM state, FIFO entry layout, header gap.
package pixel_pkg;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_RUN,
        PK_FLUSH_PEND,
        PK_FLUSH_HALF
    } pk_state_e;

    localparam int PIXEL_W          = 16;
    localparam int PIXEL_HEADER_GAP = 4;

    typedef struct packed {
        logic                 sol;
        logic                 eol;
        logic [2*PIXEL_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/pixel_packer_fifo.sv
// Synchronous FIFO with registered storage; head is read from the register array.
module sync_fifo #(
    parameter int dataWidth = 34,
    parameter int depth     = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     PUSH,
    input  logic [dataWidth-1:0]     PUSH_DATA,
    input  logic                     POP,
    output logic [dataWidth-1:0]     POP_DATA,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(depth):0]   COUNT
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [dataWidth-1:0] mem [depth];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign EMPTY    = (COUNT == '0);
    assign FULL     = (COUNT == FULL_CNT);
    assign do_pop   = POP && !EMPTY;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push  = PUSH && (!FULL || do_pop);
    assign POP_DATA = mem[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= PUSH_DATA;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs pixel pairs into tagged words and queues them for the line store.
// Build option PIXEL_PACKER_LINE_CNT_EN adds a popped-line counter output.
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int pixelWidth = 16,
    parameter int fifoDepth  = 8
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    PIXEL_VALID,
    input  logic [pixelWidth-1:0]   PIXEL_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [2*pixelWidth-1:0] OUT_DATA,
    output logic                    OUT_SOL,
    output logic                    OUT_EOL,
    output logic                    OVERFLOW,
`ifdef PIXEL_PACKER_LINE_CNT_EN
    output logic                    SEQ_ERR,
    output logic [15:0]             LINE_COUNT
`else
    output logic                    SEQ_ERR
`endif
);

    localparam int DW = 2*pixelWidth;
    localparam int CW = $clog2(fifoDepth)+1;

    typedef struct packed {
        logic          sol;
        logic          eol;
        logic [DW-1:0] data;
    } word_t;

    pk_state_e state, state_nx;

    logic [pixelWidth-1:0] lo;
    logic                  lo_valid;
    logic [DW-1:0]         pend;
    logic                  pend_valid;
    logic                  pend_sol;
    logic                  first;

    logic    push, pop, full, empty, refused;
    word_t   push_word, head;
    logic [CW-1:0] count;

    sync_fifo #(
        .dataWidth ($bits(word_t)),
        .depth     (fifoDepth)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .PUSH      (push),
        .PUSH_DATA (push_word),
        .POP       (pop),
        .POP_DATA  (head),
        .FULL      (full),
        .EMPTY     (empty),
        .COUNT     (count)
    );

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = head.data;
    assign OUT_SOL   = head.sol;
    assign OUT_EOL   = head.eol;
    assign pop       = OUT_READY && !empty;
    assign refused   = push && full && !pop;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= PK_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            PK_IDLE: if (PIXEL_VALID) state_nx = PK_RUN;
            PK_RUN: begin
                if (!PIXEL_VALID) begin
                    if (!lo_valid)                 state_nx = PK_IDLE;
                    else if (pend_valid && refused) state_nx = PK_FLUSH_PEND;
                    else                           state_nx = PK_FLUSH_HALF;
                end
            end
            PK_FLUSH_PEND: state_nx = PK_IDLE;
            PK_FLUSH_HALF: state_nx = PK_IDLE;
            default:       state_nx = PK_IDLE;
        endcase
    end

    // A completed pair is pushed once the next pixel or the line end decides its EOL
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        unique case (state)
            PK_RUN: begin
                if (pend_valid) begin
                    push           = 1'b1;
                    push_word.sol  = pend_sol;
                    push_word.eol  = !PIXEL_VALID && !lo_valid;
                    push_word.data = pend;
                end
            end
            PK_FLUSH_PEND, PK_FLUSH_HALF: begin
                push           = 1'b1;
                push_word.sol  = first;
                push_word.eol  = 1'b1;
                push_word.data = {{pixelWidth{1'b0}}, lo};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lo         <= '0;
            lo_valid   <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
            pend_sol   <= 1'b0;
            first      <= 1'b0;
            OVERFLOW   <= 1'b0;
            SEQ_ERR    <= 1'b0;
        end else begin
            if (refused) OVERFLOW <= 1'b1;
            unique case (state)
                PK_IDLE: begin
                    if (PIXEL_VALID) begin
                        lo         <= PIXEL_DATA;
                        lo_valid   <= 1'b1;
                        first      <= 1'b1;
                        pend_valid <= 1'b0;
                    end
                end
                PK_RUN: begin
                    if (PIXEL_VALID && !lo_valid) begin
                        lo         <= PIXEL_DATA;
                        lo_valid   <= 1'b1;
                        pend_valid <= 1'b0;
                    end else if (PIXEL_VALID) begin
                        pend       <= {PIXEL_DATA, lo};
                        pend_valid <= 1'b1;
                        pend_sol   <= first;
                        first      <= 1'b0;
                        lo_valid   <= 1'b0;
                    end else begin
                        pend_valid <= 1'b0;
                    end
                end
                default: begin
                    lo_valid   <= 1'b0;
                    pend_valid <= 1'b0;
                    if (PIXEL_VALID) SEQ_ERR <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIXEL_PACKER_LINE_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                   LINE_COUNT <= '0;
        else if (pop && head.eol)    LINE_COUNT <= LINE_COUNT + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer (default 16-bit pixels, depth 8).
module tb_pixel_packer;
    import pixel_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        PIXEL_VALID;
    logic [15:0] PIXEL_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_DATA;
    logic        OUT_SOL;
    logic        OUT_EOL;
    logic        OVERFLOW;
    logic        SEQ_ERR;
`ifdef PIXEL_PACKER_LINE_CNT_EN
    logic [15:0] LINE_COUNT;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [33:0] got[$];

    always #5 CLK = ~CLK;

    pixel_packer #(.pixelWidth(16), .fifoDepth(8)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .PIXEL_VALID (PIXEL_VALID),
        .PIXEL_DATA  (PIXEL_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_DATA    (OUT_DATA),
        .OUT_SOL     (OUT_SOL),
        .OUT_EOL     (OUT_EOL),
        .OVERFLOW    (OVERFLOW),
`ifdef PIXEL_PACKER_LINE_CNT_EN
        .SEQ_ERR     (SEQ_ERR),
        .LINE_COUNT  (LINE_COUNT)
`else
        .SEQ_ERR     (SEQ_ERR)
`endif
    );

    always @(negedge CLK) begin
        if (nRST && OUT_VALID && OUT_READY)
            got.push_back({OUT_SOL, OUT_EOL, OUT_DATA});
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_line(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            PIXEL_VALID = 1'b1;
            PIXEL_DATA  = base + 16'(i);
        end
        step(1);
        PIXEL_VALID = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; PIXEL_VALID = 1'b0; PIXEL_DATA = '0; OUT_READY = 1'b0;
        #2;
        n_chk++;
        if ({OUT_VALID, OUT_SOL, OUT_EOL, OVERFLOW, SEQ_ERR} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {OUT_VALID, OUT_SOL, OUT_EOL, OVERFLOW, SEQ_ERR});
        end
        n_chk++;
        if (OUT_DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00000000", OUT_DATA);
        end
        step(2);
        nRST = 1'b1;
        step(1);
    endtask

    task automatic test_even_line;
        logic [33:0] exp;
        logic [33:0] act;
        OUT_READY = 1'b1;
        got.delete();
        send_line(16'h0000, 16);
        step(20);
        n_chk++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL even_count: got %0d expected 8", got.size());
        end
        for (int k = 0; k < 8; k++) begin
            exp = {k == 0, k == 7, 16'(2*k+1), 16'(2*k)};
            act = (k < got.size()) ? got[k] : 'x;
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL even_word%0d: got %h expected %h", k, act, exp);
            end
        end
    endtask

    task automatic test_odd_line;
        logic [33:0] exp;
        logic [33:0] act;
        OUT_READY = 1'b1;
        got.delete();
        send_line(16'h0100, 17);
        step(20);
        n_chk++;
        if (got.size() != 9) begin
            n_fail++;
            $display("FAIL odd_count: got %0d expected 9", got.size());
        end
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp = {k == 0, 1'b0, 16'h0100 + 16'(2*k+1), 16'h0100 + 16'(2*k)};
            else       exp = {1'b0, 1'b1, 16'h0000, 16'h0110};
            act = (k < got.size()) ? got[k] : 'x;
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL odd_word%0d: got %h expected %h", k, act, exp);
            end
        end
    endtask

    task automatic test_single;
        logic [33:0] act;
        OUT_READY = 1'b1;
        got.delete();
        send_line(16'hBEEF, 1);
        step(20);
        act = (got.size() == 1) ? got[0] : 'x;
        n_chk++;
        if (act !== {2'b11, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL single_word: got %h (n=%0d) expected %h",
                     act, got.size(), {2'b11, 32'h0000_BEEF});
        end
    endtask

    task automatic test_latency;
        logic [33:0] a0, a1;
        OUT_READY = 1'b0;
        got.delete();
        step(1); PIXEL_VALID = 1'b1; PIXEL_DATA = 16'h0000;
        step(1); PIXEL_DATA = 16'h0001;
        step(1); PIXEL_DATA = 16'h0002;
        @(negedge CLK);
        n_chk++;
        if (OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_early_valid: got %b expected 0", OUT_VALID);
        end
        step(1); PIXEL_VALID = 1'b0;
        @(negedge CLK);
        n_chk++;
        if ({OUT_VALID, OUT_SOL, OUT_EOL, OUT_DATA} !== {3'b110, 32'h0001_0000}) begin
            n_fail++;
            $display("FAIL lat_head: got %b%b%b %h expected 110 00010000",
                     OUT_VALID, OUT_SOL, OUT_EOL, OUT_DATA);
        end
        step(3);
        n_chk++;
        if ({OUT_SOL, OUT_EOL, OUT_DATA} !== {2'b10, 32'h0001_0000}) begin
            n_fail++;
            $display("FAIL lat_stall_hold: got %b%b %h expected 10 00010000",
                     OUT_SOL, OUT_EOL, OUT_DATA);
        end
        OUT_READY = 1'b1;
        step(10);
        a0 = (got.size() > 0) ? got[0] : 'x;
        a1 = (got.size() > 1) ? got[1] : 'x;
        n_chk++;
        if (got.size() != 2 || a0 !== {2'b10, 32'h0001_0000} || a1 !== {2'b01, 32'h0000_0002}) begin
            n_fail++;
            $display("FAIL lat_words: got n=%0d %h %h expected 2 %h %h", got.size(), a0, a1,
                     {2'b10, 32'h0001_0000}, {2'b01, 32'h0000_0002});
        end
    endtask

    task automatic test_overflow;
        logic [33:0] exp;
        logic [33:0] act;
        OUT_READY = 1'b0;
        send_line(16'h1000, 16);
        step(PIXEL_HEADER_GAP);
        send_line(16'h2000, 16);
        step(PIXEL_HEADER_GAP);
        send_line(16'h3000, 16);
        step(PIXEL_HEADER_GAP);
        n_chk++;
        if ({OVERFLOW, OUT_VALID, OUT_DATA} !== {2'b11, 32'h1001_1000}) begin
            n_fail++;
            $display("FAIL ovf_state: got %b%b %h expected 11 10011000",
                     OVERFLOW, OUT_VALID, OUT_DATA);
        end
        got.delete();
        OUT_READY = 1'b1;
        step(20);
        n_chk++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d expected 8", got.size());
        end
        for (int k = 0; k < 8; k++) begin
            exp = {k == 0, k == 7, 16'h1000 + 16'(2*k+1), 16'h1000 + 16'(2*k)};
            act = (k < got.size()) ? got[k] : 'x;
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got %h expected %h", k, act, exp);
            end
        end
    endtask

    task automatic test_reset_midline;
        logic [33:0] exp;
        logic [33:0] act;
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            PIXEL_VALID = 1'b1;
            PIXEL_DATA  = 16'h4400 + 16'(i);
        end
        step(1);
        n_chk++;
        if (OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_valid: got %b expected 1", OUT_VALID);
        end
        nRST = 1'b0;
        PIXEL_VALID = 1'b0;
        #1;
        n_chk++;
        if ({OUT_VALID, OUT_SOL, OUT_EOL, OVERFLOW, SEQ_ERR, OUT_DATA} !== 37'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b%b%b%b%b %h expected all zero",
                     OUT_VALID, OUT_SOL, OUT_EOL, OVERFLOW, SEQ_ERR, OUT_DATA);
        end
        step(1);
        nRST = 1'b1;
        got.delete();
        OUT_READY = 1'b1;
        step(2);
        send_line(16'h2200, 16);
        step(20);
        n_chk++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d expected 8", got.size());
        end
        for (int k = 0; k < 8; k++) begin
            exp = {k == 0, k == 7, 16'h2200 + 16'(2*k+1), 16'h2200 + 16'(2*k)};
            act = (k < got.size()) ? got[k] : 'x;
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL midrst_word%0d: got %h expected %h", k, act, exp);
            end
        end
    endtask

    task automatic test_seq_err;
        logic [33:0] a0, a1;
        OUT_READY = 1'b1;
        got.delete();
        n_chk++;
        if (SEQ_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_pre: got %b expected 0", SEQ_ERR);
        end
        send_line(16'h0300, 3);
        step(1);
        PIXEL_VALID = 1'b1;
        PIXEL_DATA  = 16'hDEAD;
        step(1);
        PIXEL_VALID = 1'b0;
        step(20);
        n_chk++;
        if (SEQ_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_flag: got %b expected 1", SEQ_ERR);
        end
        a0 = (got.size() > 0) ? got[0] : 'x;
        a1 = (got.size() > 1) ? got[1] : 'x;
        n_chk++;
        if (got.size() != 2 || a0 !== {2'b10, 32'h0301_0300} || a1 !== {2'b01, 32'h0000_0302}) begin
            n_fail++;
            $display("FAIL seq_words: got n=%0d %h %h expected 2 %h %h", got.size(), a0, a1,
                     {2'b10, 32'h0301_0300}, {2'b01, 32'h0000_0302});
        end
    endtask

    initial begin
        test_reset();
        test_even_line();
        test_odd_line();
        test_single();
        test_latency();
        test_overflow();
        test_reset_midline();
        test_seq_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Downstream stage of the frame-sync pixel picker. Consumes its qualified pixel stream (PIXEL_VALID/PIXEL_DATA, no backpressure).
- Packs pixel pairs into 2*pixelWidth words and tags start- and end-of-line.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the line-store/DMA side.

Parameters:
- pixelWidth, 16, width of one pixel.
- fifoDepth, 8, FIFO entries; power of 2, >=2.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- PIXEL_VALID  in  1  pixel qualifier; a contiguous high run is one line.
- PIXEL_DATA  in  pixelWidth  pixel value, sampled when PIXEL_VALID=1.
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer accept; transfer when OUT_VALID&&OUT_READY.
- OUT_DATA  out  2*pixelWidth  {pixel[2k+1], pixel[2k]}; even pixel in low half.
- OUT_SOL  out  1  head word is first word of a line.
- OUT_EOL  out  1  head word is last word of a line.
- OVERFLOW  out  1  sticky: a push was dropped because the FIFO was full.
- SEQ_ERR  out  1  sticky: pixel arrived during flush and was dropped.

Behaviour:
- Reset (async, nRST=0): all outputs 0, FIFO empty, FSM=IDLE, half/pend registers cleared. Sticky flags clear only on reset.
- Internal registers:
  - lo/lo_valid: held even pixel.
  - pend/pend_valid/pend_sol: completed word awaiting its EOL decision.
- FSM states: IDLE, RUN, FLUSH_PEND, FLUSH_HALF.
- IDLE:
  - PIXEL_VALID=1: lo<=pixel, lo_valid<=1, first<=1, go to RUN.
- RUN, PIXEL_VALID=1:
  - If !lo_valid: lo<=pixel.
  - Else: push pend (EOL=0, SOL=pend_sol) if pend_valid. Then pend<={pixel,lo}, pend_sol<=first, first<=0, lo_valid<=0.
- RUN, PIXEL_VALID=0 (line end):
  - lo_valid=0: push pend with EOL=1, go to IDLE.
  - lo_valid=1, pend_valid=1: push pend with EOL=0, go to FLUSH_HALF.
  - lo_valid=1, pend_valid=0 (1-pixel line): go to FLUSH_HALF.
- FLUSH_HALF: push {0,lo} with EOL=1 and SOL=first; clear lo_valid and pend_valid; go to IDLE.
- FLUSH_PEND: reserved for a pend push blocked by full. Enter it only when a flush push is refused; it behaves as FLUSH_HALF ordering.
- At most one FIFO push per cycle.
- Pixel during FLUSH_HALF: set SEQ_ERR, drop the pixel. The upstream header guarantees a gap of >=4 cycles, so this never happens in legal traffic.
- Latency:
  - p0 at cycle t, p1 at t+1: pend loaded at end of t+1.
  - Pushed at end of t+2 (on p2 or on line end).
  - OUT_VALID=1 from cycle t+3 if the FIFO was empty.
- FIFO: registered head. A push into an empty FIFO is visible the next cycle, never combinationally.
- FIFO full with no pop this cycle: drop the push and set OVERFLOW. Push and pop in the same cycle while full is accepted; count is unchanged.
- Empty: OUT_VALID=0. OUT_DATA/OUT_SOL/OUT_EOL hold their last values, don't-care for checking.
- OUT_DATA/SOL/EOL stable while OUT_VALID&&!OUT_READY.
- Pointers wrap modulo fifoDepth. Count width is $clog2(fifoDepth)+1.
- Reset mid-line or mid-flush discards partial words and the FIFO contents.

Optional Feature:
- Macro PIXEL_PACKER_LINE_CNT_EN.
- Defined: adds output LINE_COUNT[15:0], incremented on each popped word with OUT_EOL=1. Wraps 16'hFFFF->0. Reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package pixel_pkg:
  - Packer FSM state enum.
  - Packed struct fifo entry_t {sol, eol, data}.
  - Constant PIXEL_HEADER_GAP=4.
- Sub-module sync_fifo (parameterized width/depth, push/pop/full/empty/count). The packer instantiates it with entry_t width.

Test Plan:
- 16-pixel run, values 16'h0000..16'h000F, OUT_READY=1 -> 8 words.
  - Word0 = 32'h0001_0000 with SOL=1.
  - Word7 = 32'h000F_000E with EOL=1.
  - SOL/EOL=0 on all others.
- 17-pixel run 16'h0100..16'h0110 -> 9 words; last = 32'h0000_0110 with EOL=1, prior word EOL=0.
- Single pixel 16'hBEEF -> one word 32'h0000_BEEF with SOL=1 and EOL=1.
- OUT_READY=0, three 16-pixel lines with 4-cycle gaps, fifoDepth=8 -> first 8 words retained in order, OVERFLOW=1. Then OUT_READY=1 -> exactly 8 words drain.
- nRST pulsed mid-line after 5 pixels -> outputs 0 immediately, FIFO empty. The next full line produces a correctly tagged 8 words.
- Pixel injected in the cycle after a 3-pixel line ends -> SEQ_ERR=1; line emits exactly 2 words, last with EOL=1.
